// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path (and the future receiver).
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } uart_tx_state_e;

   typedef enum logic [1:0] {
      PAR_NONE  = 2'd0,
      PAR_EVEN  = 2'd1,
      PAR_ODD   = 2'd2,
      PAR_NONE2 = 2'd3
   } uart_parity_e;

   function automatic int unsigned bit_period(input int unsigned clk_freq,
                                              input int unsigned baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// AXI-Stream beat channel feeding the UART transmitter.
interface uart_tx_frame_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] s_axis_tdata;
   logic                  s_axis_tvalid;
   logic                  s_axis_tready;

   modport master (output s_axis_tdata, output s_axis_tvalid, input s_axis_tready);
   modport slave  (input s_axis_tdata, input s_axis_tvalid, output s_axis_tready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..BIT_PERIOD-1 while enabled, held at 0 otherwise.
module uart_baud_gen #(
   parameter int unsigned BIT_PERIOD = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   output logic bit_tick
);
   localparam int unsigned CW = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;

   logic [CW-1:0] baud_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         baud_cnt <= '0;
      else if (!enable || bit_tick)
         baud_cnt <= '0;
      else
         baud_cnt <= baud_cnt + 1'b1;
   end

   assign bit_tick = (baud_cnt == CW'(BIT_PERIOD - 1));

endmodule

// File: rtl/uart_tx_frame.sv
// AXI-Stream to UART serialiser: start, DATA_WIDTH bits LSB first, optional parity, stop bits.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int unsigned BAUD_RATE  = 9600,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   uart_tx_frame_if.slave        s_axis,
   input  logic [1:0]            cfg_parity,
   output logic                  tx_wire,
   output logic                  tx_busy
);
   localparam int unsigned BIT_PERIOD = bit_period(CLK_FREQ, BAUD_RATE);
   localparam int unsigned BCW        = $clog2(DATA_WIDTH);

   uart_tx_state_e        state, state_nxt;
   logic [DATA_WIDTH-1:0] shreg;
   logic [BCW-1:0]        bit_cnt;
   logic                  baud_en;
   logic                  bit_tick;
   logic                  last_data;
   logic                  last_stop;

`ifdef UART_TX_PARITY_EN
   logic par_en;
   logic par_bit;
`else
   logic unused_cfg_parity;
   assign unused_cfg_parity = ^cfg_parity;
`endif

   assign baud_en   = (state != IDLE);
   assign last_data = (bit_cnt == BCW'(DATA_WIDTH - 1));
   assign last_stop = (bit_cnt == BCW'(STOP_BITS - 1));

   uart_baud_gen #(.BIT_PERIOD(BIT_PERIOD)) u_baud_gen (
      .clk      (clk),
      .rst      (rst),
      .enable   (baud_en),
      .bit_tick (bit_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:   if (s_axis.s_axis_tvalid) state_nxt = START;
         START:  if (bit_tick) state_nxt = DATA;
`ifdef UART_TX_PARITY_EN
         DATA:   if (bit_tick && last_data) state_nxt = par_en ? PARITY : STOP;
         PARITY: if (bit_tick) state_nxt = STOP;
`else
         DATA:   if (bit_tick && last_data) state_nxt = STOP;
`endif
         STOP:   if (bit_tick && last_stop) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Parity is taken from the beat at handshake, since shreg is consumed by shifting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg   <= '0;
         bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
         par_en  <= 1'b0;
         par_bit <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: if (s_axis.s_axis_tvalid) begin
               shreg   <= s_axis.s_axis_tdata;
               bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
               par_en  <= (uart_parity_e'(cfg_parity) == PAR_EVEN) ||
                          (uart_parity_e'(cfg_parity) == PAR_ODD);
               par_bit <= (uart_parity_e'(cfg_parity) == PAR_ODD) ?
                          ~^s_axis.s_axis_tdata : ^s_axis.s_axis_tdata;
`endif
            end
            DATA: if (bit_tick) begin
               shreg   <= shreg >> 1;
               bit_cnt <= last_data ? '0 : bit_cnt + 1'b1;
            end
            STOP: if (bit_tick) bit_cnt <= bit_cnt + 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      tx_wire = 1'b1;
      unique case (state)
         START:   tx_wire = 1'b0;
         DATA:    tx_wire = shreg[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_wire = par_bit;
`endif
         default: tx_wire = 1'b1;
      endcase
      s_axis.s_axis_tready = (state == IDLE);
      tx_busy              = (state != IDLE);
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: 8-bit/1-stop and 5-bit/2-stop instances, BIT_PERIOD=10.
// Parity expectations follow UART_TX_PARITY_EN as compiled.
module tb_uart_tx_frame;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] cfg8 = 2'd0;
   logic [1:0] cfg5 = 2'd0;
   logic       tx8, busy8, tx5, busy5;
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   uart_tx_frame_if #(.DATA_WIDTH(8)) bus8 ();
   uart_tx_frame_if #(.DATA_WIDTH(5)) bus5 ();

   uart_tx_frame #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8), .STOP_BITS(1)) u_dut (
      .clk(clk), .rst(rst), .s_axis(bus8), .cfg_parity(cfg8), .tx_wire(tx8), .tx_busy(busy8));

   uart_tx_frame #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(5), .STOP_BITS(2)) u_dut5 (
      .clk(clk), .rst(rst), .s_axis(bus5), .cfg_parity(cfg5), .tx_wire(tx5), .tx_busy(busy5));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic txw(input bit sel);
      return sel ? tx5 : tx8;
   endfunction

   function automatic logic rdy(input bit sel);
      return sel ? bus5.s_axis_tready : bus8.s_axis_tready;
   endfunction

   function automatic logic bsy(input bit sel);
      return sel ? busy5 : busy8;
   endfunction

   task automatic drive(input bit sel, input logic [8:0] d, input logic [1:0] p, input logic v);
      if (sel) begin
         bus5.s_axis_tdata = d[4:0]; cfg5 = p; bus5.s_axis_tvalid = v;
      end else begin
         bus8.s_axis_tdata = d[7:0]; cfg8 = p; bus8.s_axis_tvalid = v;
      end
   endtask

   // Called #1 after an edge with the DUT idle; leaves #1 after the first idle edge.
   task automatic run_frame(input bit sel, input string tag, input logic [8:0] data,
                            input logic [1:0] par, input int unsigned nbits,
                            input logic [15:0] exp_bits);
      logic [15:0] obs;
      int unsigned low, errs;
      check({tag, "_ready_pre"}, rdy(sel), 1'b1);
      drive(sel, data, par, 1'b1);
      @(posedge clk); #1;
      drive(sel, ~data, par + 2'd1, 1'b0);
      obs = '0; low = 0; errs = 0;
      for (int unsigned b = 0; b < nbits; b++) begin
         for (int unsigned c = 0; c < 10; c++) begin
            if (c == 0) obs[b] = txw(sel);
            else if (txw(sel) !== exp_bits[b]) errs++;
            if (rdy(sel) === 1'b0) low++;
            if (bsy(sel) !== 1'b1) errs++;
            @(posedge clk); #1;
         end
      end
      check({tag, "_bits"}, obs, exp_bits);
      check({tag, "_tready_low_cycles"}, low, nbits * 10);
      check({tag, "_glitches"}, errs, 0);
      check({tag, "_ready_post"}, rdy(sel), 1'b1);
      check({tag, "_tx_post"}, txw(sel), 1'b1);
      check({tag, "_busy_post"}, bsy(sel), 1'b0);
   endtask

   initial begin
      logic prev_rdy;
      int unsigned hs_n, s1, s2, zeros1, zeros2;

      drive(1'b0, 9'h000, 2'd0, 1'b0);
      drive(1'b1, 9'h000, 2'd0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx8", tx8, 1'b1);
      check("rst_ready8", bus8.s_axis_tready, 1'b1);
      check("rst_busy8", busy8, 1'b0);
      check("rst_tx5", tx5, 1'b1);
      check("rst_busy5", busy5, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_frame(1'b0, "8n1_a5", 9'h0A5, 2'd0, 10, 16'h034A);
      run_frame(1'b0, "8n1_c3_par3", 9'h0C3, 2'd3, 10, 16'h0386);
`ifdef UART_TX_PARITY_EN
      run_frame(1'b0, "even_a5", 9'h0A5, 2'd1, 11, 16'h054A);
      run_frame(1'b0, "odd_a5", 9'h0A5, 2'd2, 11, 16'h074A);
      run_frame(1'b0, "even_07", 9'h007, 2'd1, 11, 16'h060E);
`else
      run_frame(1'b0, "nopar_even_a5", 9'h0A5, 2'd1, 10, 16'h034A);
      run_frame(1'b0, "nopar_odd_a5", 9'h0A5, 2'd2, 10, 16'h034A);
`endif

      // Back-to-back: tvalid held across the first frame, data switched after each handshake.
      drive(1'b0, 9'h000, 2'd0, 1'b1);
      prev_rdy = bus8.s_axis_tready;
      hs_n = 0; s1 = 0; s2 = 0; zeros1 = 0; zeros2 = 0;
      for (int unsigned i = 1; i <= 240; i++) begin
         @(posedge clk); #1;
         if (prev_rdy && !bus8.s_axis_tready) begin
            hs_n++;
            if (hs_n == 1) begin
               s1 = i; bus8.s_axis_tdata = 8'hFF;
            end else begin
               s2 = i; bus8.s_axis_tvalid = 1'b0;
            end
         end
         if (tx8 === 1'b0) begin
            if (hs_n == 1) zeros1++;
            else zeros2++;
         end
         prev_rdy = bus8.s_axis_tready;
      end
      check("b2b_handshakes", hs_n, 2);
      check("b2b_start_spacing", s2 - s1, 101);
      check("b2b_zeros_frame1", zeros1, 90);
      check("b2b_zeros_frame2", zeros2, 10);
      check("b2b_idle_tx", tx8, 1'b1);

      // Reset mid-frame on an all-zero beat, then a clean follow-up frame.
      drive(1'b0, 9'h000, 2'd0, 1'b1);
      @(posedge clk); #1;
      drive(1'b0, 9'h000, 2'd0, 1'b0);
      repeat (34) begin
         @(posedge clk); #1;
      end
      check("midframe_tx_low", tx8, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("async_rst_tx", tx8, 1'b1);
      check("async_rst_ready", bus8.s_axis_tready, 1'b1);
      check("async_rst_busy", busy8, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_tx", tx8, 1'b1);
      run_frame(1'b0, "post_rst_3c", 9'h03C, 2'd0, 10, 16'h0278);

      run_frame(1'b1, "w5s2_1f", 9'h1FF, 2'd0, 8, 16'h00FE);
      run_frame(1'b1, "w5s2_0a", 9'h00A, 2'd0, 8, 16'h00D4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
